// File: rtl/approx_region_budget_ctrl.sv
// approx_region_budget_ctrl: times approximate fetch regions against a programmable budget and raises a held timeout request on overrun
module approx_region_budget_ctrl #(
   parameter int unsigned FETCH_WIDTH    = 2,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned DEFAULT_BUDGET = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_WIDTH-1:0]  cycleCounter,
   input  logic [FETCH_WIDTH-1:0] startValid,
   input  logic                   stall,
   input  logic                   endValid,
   input  logic                   flush,
   input  logic                   cfgWe,
   input  logic [DATA_WIDTH-1:0]  cfgBudget,
   input  logic                   timeoutAck,
   output logic [DATA_WIDTH-1:0]  beginCycle,
   output logic                   regionActive,
   output logic                   timeoutReq,
   output logic [DATA_WIDTH-1:0]  budget,
   output logic [15:0]            timeoutCount
);
   typedef enum logic [1:0] {IDLE, ACTIVE, TIMEOUT} state_t;
   state_t state, state_nxt;
   logic start, over;
   logic [DATA_WIDTH-1:0] elapsed;
   assign start = |startValid & ~stall & ~flush;
   // modular subtraction keeps elapsed correct across counter wrap
   assign elapsed = cycleCounter - beginCycle;
   assign over = (budget != '0) && (elapsed >= budget);
   assign regionActive = state == ACTIVE;
   assign timeoutReq = state == TIMEOUT;
   always_comb begin
      state_nxt = IDLE;
      state_nxt = (state == IDLE)    ? (start ? ACTIVE : IDLE) :
                  (state == ACTIVE)  ? ((flush | endValid) ? IDLE : (over ? TIMEOUT : ACTIVE)) :
                  (state == TIMEOUT) ? ((timeoutAck | flush) ? IDLE : TIMEOUT) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         beginCycle   <= '0;
         budget       <= DATA_WIDTH'(DEFAULT_BUDGET);
         timeoutCount <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) beginCycle <= cycleCounter;
         if (cfgWe) budget <= cfgBudget;
         if (state == ACTIVE && state_nxt == TIMEOUT && timeoutCount != 16'hFFFF)
            timeoutCount <= timeoutCount + 16'd1;
      end
   end
endmodule

// File: tb/tb_approx_region_budget_ctrl.sv
// tb_approx_region_budget_ctrl: directed and randomized checks against a per-cycle behavioural model
module tb_approx_region_budget_ctrl;
   logic        clk = 0;
   logic        rst_n;
   logic [31:0] cycleCounter;
   logic [1:0]  startValid;
   logic        stall, endValid, flush, cfgWe, timeoutAck;
   logic [31:0] cfgBudget;
   logic [31:0] beginCycle, budget;
   logic        regionActive, timeoutReq;
   logic [15:0] timeoutCount;
   int checks = 0;
   int errors = 0;
   bit          m_region, m_req;
   logic [31:0] m_begin, m_budget;
   int          m_cnt;

   approx_region_budget_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cycleCounter(cycleCounter), .startValid(startValid),
      .stall(stall), .endValid(endValid), .flush(flush), .cfgWe(cfgWe), .cfgBudget(cfgBudget),
      .timeoutAck(timeoutAck), .beginCycle(beginCycle), .regionActive(regionActive),
      .timeoutReq(timeoutReq), .budget(budget), .timeoutCount(timeoutCount)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_region = 0; m_req = 0; m_begin = 0; m_budget = 1024; m_cnt = 0;
   endtask

   // one clock: model consumes the inputs held across the edge, then the counter advances
   task automatic step();
      longint el;
      bit ov, st;
      el = (longint'(cycleCounter) - longint'(m_begin) + 64'h1_0000_0000) % 64'h1_0000_0000;
      ov = (m_budget != 0) && (el >= longint'(m_budget));
      st = (startValid != 0) && !stall && !flush;
      @(posedge clk); #1;
      if (m_req) begin
         if (timeoutAck || flush) m_req = 0;
      end else if (m_region) begin
         if (flush || endValid) m_region = 0;
         else if (ov) begin
            m_region = 0; m_req = 1;
            if (m_cnt < 65535) m_cnt++;
         end
      end else if (st) begin
         m_region = 1; m_begin = cycleCounter;
      end
      if (cfgWe) m_budget = cfgBudget;
      cycleCounter = cycleCounter + 1;
   endtask

   task automatic idle_inputs();
      startValid = 0; stall = 0; endValid = 0; flush = 0; cfgWe = 0; cfgBudget = 0; timeoutAck = 0;
   endtask

   task automatic set_budget(input logic [31:0] b);
      cfgWe = 1; cfgBudget = b; step(); cfgWe = 0;
   endtask

   task automatic test_reset();
      checks++; if (regionActive !== 1'b0) begin errors++; $display("FAIL reset_active got %0b want 0", regionActive); end
      checks++; if (timeoutReq !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", timeoutReq); end
      checks++; if (beginCycle !== 32'd0) begin errors++; $display("FAIL reset_begin got %0d want 0", beginCycle); end
      checks++; if (budget !== 32'd1024) begin errors++; $display("FAIL reset_budget got %0d want 1024", budget); end
      checks++; if (timeoutCount !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", timeoutCount); end
   endtask

   task automatic test_basic_timeout();
      int n = 0;
      int c0 = m_cnt;
      set_budget(4);
      cycleCounter = 100; startValid = 2'b01; step(); startValid = 0;
      checks++; if (beginCycle !== 32'd100) begin errors++; $display("FAIL basic_begin got %0d want 100", beginCycle); end
      checks++; if (regionActive !== 1'b1) begin errors++; $display("FAIL basic_active got %0b want 1", regionActive); end
      while (timeoutReq !== 1'b1 && n < 20) begin step(); n++; end
      checks++; if (timeoutReq !== 1'b1 || cycleCounter !== 32'd105) begin errors++; $display("FAIL basic_rise req %0b at counter %0d want 1 at 105", timeoutReq, cycleCounter); end
      checks++; if (int'(timeoutCount) !== c0 + 1) begin errors++; $display("FAIL basic_count got %0d want %0d", timeoutCount, c0 + 1); end
      timeoutAck = 1; step(); timeoutAck = 0;
      checks++; if (timeoutReq !== 1'b0) begin errors++; $display("FAIL basic_ack got %0b want 0", timeoutReq); end
      step();
   endtask

   task automatic test_normal_end();
      int c0 = m_cnt;
      bit rose = 0;
      set_budget(10);
      cycleCounter = 200; startValid = 2'b10; step(); startValid = 0;
      while (cycleCounter != 32'd205) begin step(); rose |= timeoutReq; end
      endValid = 1; step(); endValid = 0;
      rose |= timeoutReq;
      checks++; if (regionActive !== 1'b0) begin errors++; $display("FAIL end_active got %0b want 0", regionActive); end
      checks++; if (rose) begin errors++; $display("FAIL end_req got 1 want 0"); end
      checks++; if (int'(timeoutCount) !== c0) begin errors++; $display("FAIL end_count got %0d want %0d", timeoutCount, c0); end
      step();
   endtask

   task automatic test_wrap();
      int n = 0;
      set_budget(8);
      cycleCounter = 32'hFFFF_FFFC; startValid = 2'b01; step(); startValid = 0;
      while (timeoutReq !== 1'b1 && n < 20) begin step(); n++; end
      checks++; if (timeoutReq !== 1'b1 || cycleCounter !== 32'd5) begin errors++; $display("FAIL wrap_rise req %0b at counter %h want 1 at 00000005", timeoutReq, cycleCounter); end
      timeoutAck = 1; step(); timeoutAck = 0; step();
   endtask

   task automatic test_priority();
      int c0;
      flush = 1; startValid = 2'b11; step(); flush = 0; startValid = 0;
      checks++; if (regionActive !== 1'b0) begin errors++; $display("FAIL flush_start got %0b want 0", regionActive); end
      stall = 1; startValid = 2'b11; step(); stall = 0; startValid = 0;
      checks++; if (regionActive !== 1'b0) begin errors++; $display("FAIL stall_start got %0b want 0", regionActive); end
      set_budget(2);
      c0 = m_cnt;
      startValid = 2'b01; step(); startValid = 0;
      step();
      endValid = 1; step(); endValid = 0;
      checks++; if (timeoutReq !== 1'b0 || regionActive !== 1'b0) begin errors++; $display("FAIL end_vs_over req %0b active %0b want 0 0", timeoutReq, regionActive); end
      checks++; if (int'(timeoutCount) !== c0) begin errors++; $display("FAIL end_vs_over_count got %0d want %0d", timeoutCount, c0); end
      step();
      set_budget(100);
      cycleCounter = 300; startValid = 2'b01; step();
      startValid = 2'b11; repeat (3) step(); startValid = 0;
      checks++; if (beginCycle !== 32'd300 || regionActive !== 1'b1) begin errors++; $display("FAIL nested_start begin %0d active %0b want 300 1", beginCycle, regionActive); end
      endValid = 1; step(); endValid = 0; step();
   endtask

   task automatic test_config();
      int n = 0;
      bit rose = 0;
      set_budget(0);
      startValid = 2'b01; step(); startValid = 0;
      repeat (5000) begin step(); rose |= timeoutReq; end
      checks++; if (rose || regionActive !== 1'b1) begin errors++; $display("FAIL unlimited req %0b active %0b want 0 1", rose, regionActive); end
      set_budget(3);
      while (timeoutReq !== 1'b1 && n < 2) begin step(); n++; end
      checks++; if (timeoutReq !== 1'b1) begin errors++; $display("FAIL late_budget got %0b want 1", timeoutReq); end
      set_budget(0);
      checks++; if (timeoutReq !== 1'b1 || budget !== 32'd0) begin errors++; $display("FAIL write_keeps_req req %0b budget %0d want 1 0", timeoutReq, budget); end
      timeoutAck = 1; step(); timeoutAck = 0; step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         startValid = 2'($urandom);
         stall      = ($urandom_range(0, 5) == 0);
         flush      = ($urandom_range(0, 15) == 0);
         endValid   = ($urandom_range(0, 11) == 0);
         timeoutAck = ($urandom_range(0, 3) == 0);
         cfgWe      = ($urandom_range(0, 9) == 0);
         cfgBudget  = $urandom_range(0, 12);
         if ($urandom_range(0, 19) == 0) cycleCounter = $urandom;
         step();
         checks++;
         if (regionActive !== m_region || timeoutReq !== m_req || beginCycle !== m_begin ||
             budget !== m_budget || int'(timeoutCount) !== m_cnt) begin
            errors++;
            $display("FAIL random[%0d] got act %0b req %0b beg %h bud %0d cnt %0d want %0b %0b %h %0d %0d",
                     i, regionActive, timeoutReq, beginCycle, budget, timeoutCount, m_region, m_req, m_begin, m_budget, m_cnt);
         end
      end
      idle_inputs();
      timeoutAck = 1; step(); timeoutAck = 0; step();
   endtask

   task automatic test_saturation();
      set_budget(1);
      repeat (65540) begin
         startValid = 2'b01; step(); startValid = 0;
         step();
         timeoutAck = 1; step(); timeoutAck = 0;
      end
      checks++; if (timeoutCount !== 16'hFFFF) begin errors++; $display("FAIL saturate got %h want ffff", timeoutCount); end
   endtask

   task automatic test_reset_in_timeout();
      set_budget(2);
      startValid = 2'b01; step(); startValid = 0;
      step(); step();
      checks++; if (timeoutReq !== 1'b1) begin errors++; $display("FAIL pre_reset_req got %0b want 1", timeoutReq); end
      #3 rst_n = 0;
      #1;
      model_reset();
      checks++; if (timeoutReq !== 1'b0 || regionActive !== 1'b0) begin errors++; $display("FAIL async_reset req %0b active %0b want 0 0", timeoutReq, regionActive); end
      checks++; if (budget !== 32'd1024 || beginCycle !== 32'd0 || timeoutCount !== 16'd0) begin errors++; $display("FAIL async_reset_regs budget %0d begin %0d count %0d want 1024 0 0", budget, beginCycle, timeoutCount); end
      #2 rst_n = 1;
      step();
      checks++; if (timeoutReq !== 1'b0 || timeoutCount !== 16'd0) begin errors++; $display("FAIL post_reset req %0b count %0d want 0 0", timeoutReq, timeoutCount); end
   endtask

   initial begin
      rst_n = 0; cycleCounter = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      @(posedge clk); #1;
      test_reset();
      test_basic_timeout();
      test_normal_end();
      test_wrap();
      test_priority();
      test_config();
      test_random();
      test_saturation();
      test_reset_in_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
